// File: rtl/pdm_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pdm_serializer_if                                            |
// | Description : Sample valid/ready handshake into the PDM serializer.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface pdm_serializer_if;
    logic [15:0] sample_i;
    logic        sample_valid_i;
    logic        sample_ready_o;

    modport master (
        output sample_i,
        output sample_valid_i,
        input  sample_ready_o
    );

    modport slave (
        input  sample_i,
        input  sample_valid_i,
        output sample_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/pdm_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pdm_serializer                                               |
// | Description : Sample FIFO + first-order sigma-delta PDM output with bit    |
// |               clock generated in the system clock domain.                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module pdm_serializer #(
    parameter int CLK_DIV    = 50,
    parameter int OSR        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic       clock_i,
    input  wire logic       reset_ni,
    input  wire logic       enable_i,
    pdm_serializer_if.slave smp,
    output logic            pdm_o,
    output logic            pdm_clk_o,
    output logic            sd_o,
    output logic            underrun_o
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W = $clog2(OSR);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [15:0]        c_SILENCE  = 16'h8000;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(OSR - 1);

    logic               r_enable;
    logic [c_DIV_W-1:0] r_div;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [15:0]        r_acc;
    logic [15:0]        r_cur;
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic [15:0]        r_mem [FIFO_DEPTH];

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_div_wrap;
    logic               w_tick;
    logic               w_load;
    logic               w_pop;
    logic [15:0]        w_next_sample;
    logic [16:0]        w_sum;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

    assign smp.sample_ready_o = r_enable & ~w_full;
    assign sd_o               = r_enable;

    assign w_push     = r_enable & smp.sample_valid_i & ~w_full;
    assign w_div_wrap = (r_div == c_DIV_LAST);
    // Bit tick is the 1->0 transition of the bit clock.
    assign w_tick     = r_enable & w_div_wrap & pdm_clk_o;
    assign w_load     = w_tick & (r_bit_cnt == '0);
    assign w_pop      = w_load & ~w_empty;

    always_comb begin
        w_next_sample = r_cur;
        if (w_load) begin
            w_next_sample = w_empty ? c_SILENCE : r_mem[r_rd_ptr[c_PTR_W-1:0]];
        end
        w_sum = {1'b0, r_acc} + {1'b0, w_next_sample};
    end

    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= smp.sample_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_enable   <= 1'b0;
            r_div      <= '0;
            r_bit_cnt  <= '0;
            r_acc      <= '0;
            r_cur      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            pdm_clk_o  <= 1'b0;
            pdm_o      <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            r_enable   <= enable_i;
            underrun_o <= 1'b0;
            if (!r_enable) begin
                // Idle: everything held flushed so a restart sees full latency.
                r_div     <= '0;
                r_bit_cnt <= '0;
                r_acc     <= '0;
                r_cur     <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                pdm_clk_o <= 1'b0;
                pdm_o     <= 1'b0;
            end else begin
                r_div <= w_div_wrap ? '0 : r_div + c_DIV_W'(1);
                if (w_div_wrap) begin
                    pdm_clk_o <= ~pdm_clk_o;
                end
                if (w_tick) begin
                    r_bit_cnt  <= (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + c_BIT_W'(1);
                    r_cur      <= w_next_sample;
                    r_acc      <= w_sum[15:0];
                    pdm_o      <= w_sum[16];
                    underrun_o <= w_load & w_empty;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + (c_PTR_W + 1)'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + (c_PTR_W + 1)'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pdm_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pdm_serializer                                            |
// | Description : Self-checking bench with a time-based sigma-delta model.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_pdm_serializer;
    localparam int CLK_DIV = 2;
    localparam int OSR     = 16;
    localparam int DEPTH   = 4;
    localparam int TICK    = 2 * CLK_DIV;

    logic clock_i  = 1'b0;
    logic reset_ni = 1'b0;
    logic enable_i = 1'b0;
    logic pdm_o, pdm_clk_o, sd_o, underrun_o;

    pdm_serializer_if bus();

    pdm_serializer #(.CLK_DIV(CLK_DIV), .OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .enable_i   (enable_i),
        .smp        (bus),
        .pdm_o      (pdm_o),
        .pdm_clk_o  (pdm_clk_o),
        .sd_o       (sd_o),
        .underrun_o (underrun_o)
    );

    always #5 clock_i = ~clock_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int und_cnt  = 0;
    int first_cyc = -1;
    bit dut_bits[$];
    bit model_bits[$];

    // Model: time since registered enable decides clock phase and ticks;
    // the sample stream is a plain queue and the modulator plain integer math.
    bit          m_en, m_tick, push_ok;
    int          m_t, m_acc, m_cur, m_nticks;
    logic [15:0] m_q[$];
    bit          e_clk, e_pdm, e_und, e_ready, e_sd;

    always @(posedge clock_i) cyc++;

    always @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            m_en = 0; m_t = 0; m_q.delete(); m_acc = 0; m_cur = 0; m_nticks = 0;
            e_clk = 0; e_pdm = 0; e_und = 0; m_tick = 0;
        end else begin
            push_ok = m_en && bus.sample_valid_i && (m_q.size() < DEPTH);
            m_tick  = 0;
            e_und   = 0;
            if (!m_en) begin
                m_t = 0; m_q.delete(); m_acc = 0; m_nticks = 0;
                e_clk = 0; e_pdm = 0;
            end else begin
                m_t++;
                e_clk = ((m_t / CLK_DIV) % 2) == 1;
                if (m_t % TICK == 0) begin
                    m_tick = 1;
                    if (m_nticks % OSR == 0) begin
                        if (m_q.size() > 0) m_cur = m_q.pop_front();
                        else begin m_cur = 'h8000; e_und = 1; end
                    end
                    m_nticks++;
                    m_acc = m_acc + m_cur;
                    e_pdm = m_acc >= 65536;
                    m_acc = m_acc % 65536;
                end
            end
            if (push_ok) m_q.push_back(bus.sample_i);
            m_en = enable_i;
        end
        e_sd    = m_en;
        e_ready = m_en && (m_q.size() < DEPTH);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock_i) begin
        chk("pdm_o",          pdm_o,              e_pdm);
        chk("pdm_clk_o",      pdm_clk_o,          e_clk);
        chk("underrun_o",     underrun_o,         e_und);
        chk("sd_o",           sd_o,               e_sd);
        chk("sample_ready_o", bus.sample_ready_o, e_ready);
        if (m_tick) begin
            if (first_cyc < 0) first_cyc = cyc;
            dut_bits.push_back(pdm_o);
            model_bits.push_back(e_pdm);
        end
        if (underrun_o === 1'b1) und_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock_i);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        bus.sample_i = v;
        bus.sample_valid_i = 1'b1;
        cycles(1);
        bus.sample_valid_i = 1'b0;
    endtask

    task automatic wait_bits(input int n);
        int guard = 0;
        while (dut_bits.size() < n && guard < 20000) begin
            @(posedge clock_i);
            guard++;
        end
        #1;
        if (dut_bits.size() < n) begin
            checks++;
            failures++;
            $display("FAIL wait_bits actual=%0d required=%0d", dut_bits.size(), n);
        end
    endtask

    function automatic int win_ones(input int start, input bit from_model);
        int n = 0;
        for (int i = 0; i < OSR; i++) n += from_model ? int'(model_bits[start+i]) : int'(dut_bits[start+i]);
        return n;
    endfunction

    function automatic logic [15:0] win_pat(input int start);
        logic [15:0] p = '0;
        for (int i = 0; i < OSR; i++) p[15-i] = dut_bits[start+i];
        return p;
    endfunction

    task automatic check_win(input string nm, input int start, input int ones);
        chk(nm, win_ones(start, 0), ones);
        chk({nm, "_model"}, win_ones(start, 1), ones);
    endtask

    initial begin
        int t0, tg, acc, nb;
        logic prev;
        bus.sample_i = '0;
        bus.sample_valid_i = 1'b0;

        cycles(5);
        chk("rst_pdm", pdm_o, 0);
        chk("rst_clk", pdm_clk_o, 0);
        chk("rst_sd", sd_o, 0);
        chk("rst_ready", bus.sample_ready_o, 0);
        chk("rst_und", underrun_o, 0);
        reset_ni = 1'b1;

        tg = 0;
        prev = pdm_clk_o;
        repeat (10000) begin
            @(negedge clock_i);
            if (pdm_clk_o !== prev) tg++;
            prev = pdm_clk_o;
        end
        chk("idle_toggles", tg, 0);
        cycles(1);

        // Silence, extremes, then underrun with resume.
        first_cyc = -1;
        enable_i = 1'b1;
        t0 = cyc;
        cycles(1);
        push(16'h8000);
        push(16'h0000);
        push(16'hFFFF);
        wait_bits(49);
        chk("first_tick_latency", first_cyc - t0, 5);
        check_win("silence_ones", 0, 8);
        chk("silence_pattern", win_pat(0), 16'h5555);
        check_win("zero_ones", 16, 0);
        check_win("full_ones", 32, 15);
        chk("full_pattern", win_pat(32), 16'h7FFF);
        chk("und_first", und_cnt, 1);
        wait_bits(65);
        chk("und_second", und_cnt, 2);
        push(16'h4000);
        wait_bits(81);
        chk("und_resume", und_cnt, 2);
        chk("und_pattern_a", win_pat(48), 16'hAAAA);
        chk("und_pattern_b", win_pat(64), 16'hAAAA);

        // Backpressure: six back-to-back offers, only four fit.
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.sample_i = (i == 0) ? 16'h2000 : (i == 1) ? 16'hC000 : (i == 2) ? 16'h1000 :
                           (i == 3) ? 16'hF000 : 16'(i);
            bus.sample_valid_i = 1'b1;
            if (bus.sample_ready_o === 1'b1) acc++;
            cycles(1);
        end
        bus.sample_valid_i = 1'b0;
        chk("bp_accepted", acc, 4);
        chk("bp_ready_low", bus.sample_ready_o, 0);
        wait_bits(162);
        check_win("resume_4000", 80, 4);
        check_win("bp_2000", 96, 2);
        check_win("bp_C000", 112, 12);
        check_win("bp_1000", 128, 1);
        check_win("bp_F000", 144, 15);
        chk("und_after_bp", und_cnt, 3);

        // Abort mid-sample with data still queued.
        push(16'h1234);
        push(16'h5678);
        enable_i = 1'b0;
        cycles(2);
        chk("abort_clk", pdm_clk_o, 0);
        chk("abort_pdm", pdm_o, 0);
        chk("abort_ready", bus.sample_ready_o, 0);
        chk("abort_sd", sd_o, 0);
        cycles(3);
        first_cyc = -1;
        enable_i = 1'b1;
        t0 = cyc;
        nb = dut_bits.size();
        wait_bits(nb + 1);
        chk("reenable_latency", first_cyc - t0, 5);
        chk("reenable_flushed", und_cnt, 4);

        // Asynchronous reset mid-stream.
        cycles(9);
        #3;
        reset_ni = 1'b0;
        #1;
        chk("async_rst_clk", pdm_clk_o, 0);
        chk("async_rst_pdm", pdm_o, 0);
        chk("async_rst_sd", sd_o, 0);
        chk("async_rst_ready", bus.sample_ready_o, 0);
        cycles(2);
        first_cyc = -1;
        reset_ni = 1'b1;
        t0 = cyc;
        nb = dut_bits.size();
        cycles(1);
        push(16'h6000);
        push(16'hA000);
        wait_bits(nb + 33);
        chk("post_rst_latency", first_cyc - t0, 5);
        check_win("post_rst_6000", nb, 6);
        check_win("post_rst_A000", nb + 16, 10);

        enable_i = 1'b0;
        cycles(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pdm_serializer.md
# pdm_serializer

Audio-output counterpart of the PDM microphone deserializer: accepts 16-bit unsigned density samples through a valid/ready handshake, buffers them in a small FIFO, and emits a 1-bit pulse-density stream with a divided bit clock for the board's audio amplifier/low-pass output. A first-order sigma-delta modulator converts each sample into OSR output bits. Everything runs in the system clock domain; the bit clock is a generated output only, never used internally as a clock.

## Interface
- CLK_DIV, 50: system clocks per half period of pdm_clk_o (50 gives 1 MHz at 100 MHz).
- OSR, 16: PDM bits emitted per input sample; must be a power of two ≥ 2.
- FIFO_DEPTH, 4: sample FIFO entries; power of two ≥ 2.
- clock_i  input  1  system clock; all state updates on its rising edge.
- reset_ni  input  1  asynchronous, active-low reset.
- enable_i  input  1  run request; low = idle and flushed.
- sample_i  input  16  unsigned density; fraction of ones = sample_i/65536.
- sample_valid_i  input  1  sample_i valid this cycle.
- sample_ready_o  output  1  FIFO can accept; push when valid and ready both high.
- pdm_o  output  1  PDM data bit, changes only on falling edge of pdm_clk_o.
- pdm_clk_o  output  1  bit clock, 50% duty, period 2×CLK_DIV clocks.
- sd_o  output  1  amplifier enable; equals registered enable_i.
- underrun_o  output  1  one-cycle pulse when a sample is needed and FIFO empty.

## Operation
- Reset (reset_ni low): pdm_o=0, pdm_clk_o=0, sd_o=0, sample_ready_o=0, underrun_o=0; divider, bit counter, accumulator, FIFO pointers cleared.
- Idle (enable_i low, registered): divider and bit counter held at 0, pdm_clk_o=0, pdm_o=0, accumulator cleared, FIFO flushed, sample_ready_o=0. Dropping enable mid-sample aborts immediately; no partial sample is finished.
- Run: sample_ready_o = FIFO not full. Push with ready low is ignored (sample lost, no error).
- Divider counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and pdm_clk_o toggles. A toggle from 1 to 0 is a bit tick.
- Bit counter 0..OSR-1, advances on each bit tick, wraps to 0.
- On a bit tick with bit counter 0: pop FIFO head into the current-sample register; if FIFO empty, load 0x8000 (silence) and pulse underrun_o.
- On every bit tick: acc[16:0] = {1'b0, acc[15:0]} + current sample (the newly loaded one on a load tick); pdm_o <= acc[16]; accumulator keeps acc[15:0].
- Push and pop in the same cycle: both occur; level unchanged. Pop when full frees a slot; sample_ready_o rises the next cycle.

## Timing
- enable_i is registered once; sd_o follows enable_i by 1 cycle.
- First rising pdm_clk_o edge CLK_DIV cycles after registered enable; first bit tick (first pdm_o update, first pop) 2×CLK_DIV cycles after it.
- One sample consumed every OSR×2×CLK_DIV clocks (1600 at defaults: 62.5 kS/s at 100 MHz).
- pdm_o is stable for a full pdm_clk_o period around each rising edge; downstream samples on rising edge.
- underrun_o is high exactly the cycle of the load tick; never high in idle.
- Reset asserted mid-stream: all outputs reach reset values asynchronously; no tick is generated on release until the full 2×CLK_DIV sequence elapses.

## Test plan
- Reset/idle: hold reset_ni low, then release with enable_i=0 -> all outputs 0, pdm_clk_o static for 10000 cycles.
- Silence: push 0x8000 with enable high -> pdm_o sequence 0,1,0,1,… per bit tick, exactly 8 ones in 16 bits; first tick 2×CLK_DIV cycles after enable.
- Extremes: push 0x0000 then 0xFFFF -> first 16 bits all 0; next 16 bits 0 then fifteen 1s (accumulator carries starting from residue 0).
- Backpressure: push 6 samples back-to-back with CLK_DIV=2 -> sample_ready_o low after 4 accepted; 5th/6th dropped unless ready high; pops occur every 64 cycles; density of each output window matches its sample.
- Underrun: after FIFO drains -> underrun_o single-cycle pulse at each load tick, pdm_o alternating (0x8000); new push resumes normal data at next sample boundary.
- Abort: drop enable_i mid-sample -> next cycle after registration pdm_clk_o=0, pdm_o=0, sample_ready_o=0, FIFO empty; re-enable restarts with fresh 2×CLK_DIV latency.
